// File: rtl/ntsc_pattern_pkg.sv
// Shared definitions for the NTSC test-pattern sequencer: mode codes, colour-bar
// flags and the auto-cycle successor function.
package ntsc_pattern_pkg;

    localparam logic [2:0] MODE_EXT       = 3'd0;
    localparam logic [2:0] MODE_BARS      = 3'd1;
    localparam logic [2:0] MODE_PALETTE   = 3'd2;
    localparam logic [2:0] MODE_CHECKER   = 3'd3;
    localparam logic [2:0] MODE_RAMP      = 3'd4;
    localparam logic [2:0] MODE_SCROLL    = 3'd5;
    localparam logic [2:0] MODE_COMPOSITE = 3'd6;
    localparam logic [2:0] MODE_SOLID     = 3'd7;

    // {R,G,B} on/off per bar; element 0 is the leftmost bar (white).
    localparam logic [7:0][2:0] BAR_FLAGS = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    // Auto-cycle walks 1..7 and wraps; EXT is never entered automatically.
    function automatic logic [2:0] next_mode(input logic [2:0] m);
        return (m == MODE_SOLID || m == MODE_EXT) ? MODE_BARS : m + 3'd1;
    endfunction

endpackage

// File: rtl/ntsc_pattern_core.sv
// Combinational pattern generator: maps pixel position, scroll offset and the
// committed mode onto one packed {R,G,B} colour.
module ntsc_pattern_core
    import ntsc_pattern_pkg::*;
#(
    parameter int R_BITS   = 3,
    parameter int G_BITS   = 3,
    parameter int B_BITS   = 2,
    parameter int H_ACTIVE = 512,
    parameter int BAND_H   = 48,
    localparam int RGB_W   = R_BITS + G_BITS + B_BITS,
    localparam int XW      = $clog2(H_ACTIVE)
) (
    input  logic [9:0]       x,
    input  logic [8:0]       y,
    input  logic [XW-1:0]    scroll,
    input  logic [RGB_W-1:0] ext_rgb,
    input  logic [2:0]       mode,
    output logic [RGB_W-1:0] color
);

    localparam int PW = XW + RGB_W;

    function automatic logic [RGB_W-1:0] expand_flags(input logic [2:0] f);
        return {{R_BITS{f[2]}}, {G_BITS{f[1]}}, {B_BITS{f[0]}}};
    endfunction

    logic [XW-1:0]    w_xt;
    logic [XW-1:0]    w_xs;
    logic [PW-1:0]    w_xpad;
    logic [RGB_W-1:0] w_bars;
    logic [RGB_W-1:0] w_sbars;
    logic [RGB_W-1:0] w_palette;
    logic [RGB_W-1:0] w_ramp;
    logic [RGB_W-1:0] w_checker;
    logic             w_unused_bits;

    assign w_xt = x[XW-1:0];
    assign w_xs = w_xt + scroll;

    // Zero padding below x left-justifies it when the line is narrower than RGB_W.
    assign w_xpad    = {w_xt, {RGB_W{1'b0}}};
    assign w_palette = w_xpad[PW-1 -: RGB_W];
    assign w_ramp    = {w_xpad[PW-1 -: R_BITS], w_xpad[PW-1 -: G_BITS], w_xpad[PW-1 -: B_BITS]};

    assign w_bars    = expand_flags(BAR_FLAGS[w_xt[XW-1 -: 3]]);
    assign w_sbars   = expand_flags(BAR_FLAGS[w_xs[XW-1 -: 3]]);
    assign w_checker = {RGB_W{x[4] ^ y[4]}};

    assign w_unused_bits = &{1'b0, x[9:XW], w_xpad[RGB_W-1:0]};

    always_comb begin
        color = '0;
        case (mode)
            MODE_EXT:     color = ext_rgb;
            MODE_BARS:    color = w_bars;
            MODE_PALETTE: color = w_palette;
            MODE_CHECKER: color = w_checker;
            MODE_RAMP:    color = w_ramp;
            MODE_SCROLL:  color = w_sbars;
            MODE_COMPOSITE: begin
                if (int'(y) < BAND_H)
                    color = ext_rgb;
                else if (int'(y) < 4 * BAND_H)
                    color = w_palette;
                else
                    color = w_bars;
            end
            default:      color = '1;
        endcase
    end

endmodule

// File: rtl/ntsc_pattern_sequencer.sv
// Test-pattern source for the NTSC encoder: frame-synchronous mode commit,
// optional auto-cycle, per-frame scroll and a registered RGB output.
module ntsc_pattern_sequencer
    import ntsc_pattern_pkg::*;
#(
    parameter int         R_BITS       = 3,
    parameter int         G_BITS       = 3,
    parameter int         B_BITS       = 2,
    parameter int         H_ACTIVE     = 512,
    parameter int         BAND_H       = 48,
    parameter int         DWELL_FRAMES = 120,
    parameter int         SCROLL_STEP  = 2,
    parameter logic [2:0] DEFAULT_MODE = 3'd6,
    localparam int        RGB_W        = R_BITS + G_BITS + B_BITS,
    localparam int        XW           = $clog2(H_ACTIVE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       x,
    input  logic [8:0]       y,
    input  logic             active_video,
    input  logic             frame_start,
    input  logic [RGB_W-1:0] ext_rgb,
    input  logic [2:0]       mode_in,
    input  logic             mode_load,
    input  logic             auto_en,
    output logic [RGB_W-1:0] rgb,
    output logic [2:0]       mode,
    output logic [XW-1:0]    scroll
);

    localparam int            DW         = $clog2(DWELL_FRAMES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
    localparam logic [XW-1:0] STEP       = XW'(SCROLL_STEP);

    logic [RGB_W-1:0] r_rgb;
    logic [2:0]       r_mode;
    logic [2:0]       r_pending;
    logic [DW-1:0]    r_dwell;
    logic [XW-1:0]    r_scroll;
    logic             r_load_seen;
    logic [RGB_W-1:0] w_color;
    logic [2:0]       w_next;

    assign w_next = next_mode(r_mode);

    ntsc_pattern_core #(
        .R_BITS   (R_BITS),
        .G_BITS   (G_BITS),
        .B_BITS   (B_BITS),
        .H_ACTIVE (H_ACTIVE),
        .BAND_H   (BAND_H)
    ) u_core (
        .x       (x),
        .y       (y),
        .scroll  (r_scroll),
        .ext_rgb (ext_rgb),
        .mode    (r_mode),
        .color   (w_color)
    );

    // r_load_seen remembers a mid-frame load so auto-cycle commits it instead of advancing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rgb       <= '0;
            r_mode      <= DEFAULT_MODE;
            r_pending   <= DEFAULT_MODE;
            r_dwell     <= '0;
            r_scroll    <= '0;
            r_load_seen <= 1'b0;
        end else begin
            r_rgb <= active_video ? w_color : '0;
            if (frame_start) begin
                r_scroll    <= r_scroll + STEP;
                r_load_seen <= 1'b0;
                if (mode_load) begin
                    r_mode    <= mode_in;
                    r_pending <= mode_in;
                    r_dwell   <= '0;
                end else if (!auto_en) begin
                    r_mode <= r_pending;
                end else if (r_load_seen) begin
                    r_mode  <= r_pending;
                    r_dwell <= '0;
                end else if (r_dwell == DWELL_LAST) begin
                    r_dwell   <= '0;
                    r_mode    <= w_next;
                    r_pending <= w_next;
                end else begin
                    r_dwell <= r_dwell + 1'b1;
                end
            end else if (mode_load) begin
                r_pending   <= mode_in;
                r_dwell     <= '0;
                r_load_seen <= 1'b1;
            end
        end
    end

    assign rgb    = r_rgb;
    assign mode   = r_mode;
    assign scroll = r_scroll;

endmodule

// File: tb/tb_ntsc_pattern_sequencer.sv
// Bench for ntsc_pattern_sequencer: constant-expectation vectors, multi-cycle
// mode/scroll sequences and a randomized run against an arithmetic model.
module tb_ntsc_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x;
    logic [8:0] y;
    logic       av;
    logic       fs;
    logic [7:0] ext;
    logic [2:0] mode_in;
    logic       ml;
    logic       ae;
    logic [7:0] rgb;
    logic [2:0] mode;
    logic [8:0] scroll;

    int n_tests = 0;
    int n_fail  = 0;

    int m_mode, m_pend, m_dwell, m_scroll;
    bit m_seen;

    always #5 clk = ~clk;

    ntsc_pattern_sequencer #(.DWELL_FRAMES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .x            (x),
        .y            (y),
        .active_video (av),
        .frame_start  (fs),
        .ext_rgb      (ext),
        .mode_in      (mode_in),
        .mode_load    (ml),
        .auto_en      (ae),
        .rgb          (rgb),
        .mode         (mode),
        .scroll       (scroll)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Bars in order white,yellow,cyan,green,magenta,red,blue,black in 3-3-2.
    function automatic int bar(input int b);
        return (((b & 2) != 0) ? 0 : 224) | ((b < 4) ? 28 : 0) | (((b % 2) == 0) ? 3 : 0);
    endfunction

    function automatic int ref_color(input int md, input int xx, input int yy, input int e, input int sc);
        int xt;
        xt = xx % 512;
        case (md)
            0: return e;
            1: return bar(xt / 64);
            2: return xt / 2;
            3: return (((xx / 16) % 2) != ((yy / 16) % 2)) ? 255 : 0;
            4: return (xt / 64) * 32 + (xt / 64) * 4 + xt / 128;
            5: return bar(((xt + sc) % 512) / 64);
            6: begin
                if (yy < 48) return e;
                else if (yy < 192) return xt / 2;
                else return bar(xt / 64);
            end
            default: return 255;
        endcase
    endfunction

    // Predict the edge from the current inputs, clock it, compare all outputs.
    task automatic tick();
        int e;
        e = av ? ref_color(m_mode, int'(x), int'(y), int'(ext), m_scroll) : 0;
        if (!rst) begin
            e = 0; m_mode = 6; m_pend = 6; m_dwell = 0; m_scroll = 0; m_seen = 0;
        end else if (fs) begin
            m_scroll = (m_scroll + 2) % 512;
            if (ml) begin
                m_mode = int'(mode_in); m_pend = m_mode; m_dwell = 0;
            end else if (!ae) begin
                m_mode = m_pend;
            end else if (m_seen) begin
                m_mode = m_pend; m_dwell = 0;
            end else begin
                m_dwell++;
                if (m_dwell == 2) begin
                    m_dwell = 0; m_mode = m_mode % 7 + 1; m_pend = m_mode;
                end
            end
            m_seen = 0;
        end else if (ml) begin
            m_pend = int'(mode_in); m_dwell = 0; m_seen = 1;
        end
        @(posedge clk);
        #1;
        check("rgb", 32'(rgb), 32'(e));
        check("mode", 32'(mode), 32'(m_mode));
        check("scroll", 32'(scroll), 32'(m_scroll));
    endtask

    task automatic quiet();
        fs = 0; ml = 0; ae = 0; av = 0; mode_in = 0;
    endtask

    task automatic frame();
        tick();
        fs = 1; tick(); fs = 0;
    endtask

    task automatic set_mode(input logic [2:0] m);
        ae = 0; mode_in = m; ml = 1; fs = 1; tick(); ml = 0; fs = 0;
    endtask

    task automatic do_reset();
        rst = 0; tick(); rst = 1;
    endtask

    typedef struct {
        logic [2:0] md;
        logic [9:0] vx;
        logic [8:0] vy;
        logic [7:0] ve;
        logic       va;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{3'd6, 10'd0,   9'd10,  8'hA5, 1'b1, 8'hA5};
        tbl[1]  = '{3'd6, 10'd256, 9'd100, 8'hA5, 1'b1, 8'h80};
        tbl[2]  = '{3'd6, 10'd256, 9'd100, 8'hA5, 1'b0, 8'h00};
        tbl[3]  = '{3'd6, 10'd320, 9'd250, 8'h11, 1'b1, 8'hE0};
        tbl[4]  = '{3'd1, 10'd0,   9'd0,   8'h00, 1'b1, 8'hFF};
        tbl[5]  = '{3'd1, 10'd200, 9'd0,   8'h00, 1'b1, 8'h1C};
        tbl[6]  = '{3'd1, 10'd600, 9'd7,   8'h00, 1'b1, 8'hFC};
        tbl[7]  = '{3'd2, 10'd3,   9'd0,   8'h00, 1'b1, 8'h01};
        tbl[8]  = '{3'd2, 10'd511, 9'd0,   8'h00, 1'b1, 8'hFF};
        tbl[9]  = '{3'd3, 10'd16,  9'd0,   8'h00, 1'b1, 8'hFF};
        tbl[10] = '{3'd3, 10'd16,  9'd16,  8'h00, 1'b1, 8'h00};
        tbl[11] = '{3'd4, 10'd128, 9'd0,   8'h00, 1'b1, 8'h49};
        tbl[12] = '{3'd4, 10'd511, 9'd0,   8'h00, 1'b1, 8'hFF};
        tbl[13] = '{3'd0, 10'd9,   9'd9,   8'h5A, 1'b1, 8'h5A};
        tbl[14] = '{3'd7, 10'd9,   9'd9,   8'h00, 1'b0, 8'h00};
        tbl[15] = '{3'd7, 10'd700, 9'd300, 8'h00, 1'b1, 8'hFF};

        x = 0; y = 0; ext = 0;
        m_mode = 6; m_pend = 6; m_dwell = 0; m_scroll = 0; m_seen = 0;
        quiet();

        // Reset held with random inputs
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            x = 10'($urandom); y = 9'($urandom); ext = 8'($urandom);
            av = 1'($urandom); fs = 1'($urandom); ml = 1'($urandom);
            ae = 1'($urandom); mode_in = 3'($urandom);
            tick();
        end
        check("rst_rgb", 32'(rgb), 32'h0);
        check("rst_mode", 32'(mode), 32'd6);
        check("rst_scroll", 32'(scroll), 32'd0);
        rst = 1; quiet();
        fs = 1; tick(); fs = 0;
        check("first_fs_mode", 32'(mode), 32'd6);

        // Manual load mid-frame
        mode_in = 1; ml = 1; tick(); ml = 0; mode_in = 0;
        tick(); tick();
        check("manual_hold", 32'(mode), 32'd6);
        fs = 1; tick(); fs = 0;
        check("manual_commit", 32'(mode), 32'd1);
        av = 1; x = 64; y = 20; tick();
        check("bars_x64", 32'(rgb), 32'hFC);
        x = 448; tick();
        check("bars_x448", 32'(rgb), 32'h00);
        av = 0; tick();
        check("blank", 32'(rgb), 32'h00);

        // Load coincident with frame_start
        mode_in = 7; ml = 1; fs = 1; tick(); ml = 0; fs = 0;
        check("simul_mode", 32'(mode), 32'd7);
        av = 1; x = 5; tick(); av = 0;
        check("simul_solid", 32'(rgb), 32'hFF);

        // Auto-cycle with a dwell of two frames
        ae = 1;
        repeat (2) frame();
        check("auto_2", 32'(mode), 32'd1);
        repeat (2) frame();
        check("auto_4", 32'(mode), 32'd2);
        frame();
        mode_in = 5; ml = 1; tick(); ml = 0; tick();
        check("auto_load_hold", 32'(mode), 32'd2);
        frame();
        check("auto_load_commit", 32'(mode), 32'd5);
        frame();
        check("auto_dwell_a", 32'(mode), 32'd5);
        frame();
        check("auto_dwell_b", 32'(mode), 32'd6);
        ae = 0;

        // Scroll animation and wrap
        do_reset();
        set_mode(3'd5);
        repeat (31) frame();
        check("scroll_64", 32'(scroll), 32'd64);
        av = 1; x = 0; y = 0; tick(); av = 0;
        check("scroll_bar_yellow", 32'(rgb), 32'hFC);
        repeat (224) frame();
        check("scroll_wrap", 32'(scroll), 32'd0);

        // Constant-expectation vectors
        for (int i = 0; i < 16; i++) begin
            if (mode != tbl[i].md) set_mode(tbl[i].md);
            x = tbl[i].vx; y = tbl[i].vy; ext = tbl[i].ve; av = tbl[i].va;
            tick();
            check($sformatf("vec%0d", i), 32'(rgb), 32'(tbl[i].exp));
        end
        quiet();

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) ae = 1'($urandom);
            x = 10'($urandom); y = 9'($urandom); ext = 8'($urandom);
            av = ($urandom_range(3) != 0);
            fs = ($urandom_range(15) == 0);
            ml = ($urandom_range(19) == 0);
            mode_in = 3'($urandom);
            rst = ($urandom_range(499) != 0);
            tick();
        end
        rst = 1; quiet();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ntsc_pattern_sequencer.md
Name: ntsc_pattern_sequencer

Overview:
- Parametrised test-pattern source for the NTSC shield video path; successor to the fixed stacked font/palette/colour-bar test top.
- Selects one of eight pattern modes and muxes the result; it does not sum them.
- Mode changes take effect only on frame boundaries. An optional auto-cycle walks the modes on a frame-count dwell, and a per-frame scroll offset animates one mode.
- Registered output feeds the ntsc encoder's rgb input.

Parameters:
- R_BITS, 3, red channel width
- G_BITS, 3, green channel width
- B_BITS, 2, blue channel width; RGB_W = R_BITS+G_BITS+B_BITS, packed {R,G,B}
- H_ACTIVE, 512, active pixels per line; power of two, 64..512
- BAND_H, 48, band height in lines for COMPOSITE mode
- DWELL_FRAMES, 120, frames per mode in auto-cycle; minimum 1
- SCROLL_STEP, 2, pixels added to the scroll offset per frame
- DEFAULT_MODE, 3'd6, mode loaded at reset

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-low reset; 0 = reset
- x  in  10  horizontal pixel
- y  in  9  vertical pixel
- active_video  in  1  high during the active picture
- frame_start  in  1  one-cycle pulse, once per frame, in vertical blanking
- ext_rgb  in  RGB_W  external source (font generator); cycle-aligned with x/y
- mode_in  in  3  requested mode
- mode_load  in  1  one-cycle strobe; captures mode_in into pending
- auto_en  in  1  level; enables auto-cycle
- rgb  out  RGB_W  registered pixel colour
- mode  out  3  currently committed mode
- scroll  out  log2(H_ACTIVE)  current scroll offset

Behaviour:
- Reset (rst=0 at a clk edge): rgb=0, mode=pending=DEFAULT_MODE, scroll=0, dwell=0. The reset value of rst has priority over all other inputs.
- Latency: rgb is registered, 1 clk after x/y/ext_rgb. If active_video=0, rgb=0 on the next cycle.
- Pending register: on mode_load, pending<=mode_in. mode_load also clears dwell.
- Commit on frame_start:
  - Manual (auto_en=0): mode<=pending. The pending value includes a same-cycle mode_load, so mode_in is committed directly.
  - Auto (auto_en=1, no mode_load): dwell<=dwell+1. When dwell==DWELL_FRAMES-1, dwell<=0 and mode<=next(mode); pending tracks mode.
  - Auto with a same-cycle mode_load: mode<=mode_in and dwell<=0.
  - next(): 1→2→…→7→1. Mode 0 is never entered by auto-cycle; if mode is 0, next is 1.
- scroll<=(scroll+SCROLL_STEP) mod H_ACTIVE on every frame_start, in all modes. The add wraps naturally with width log2(H_ACTIVE).
- Bar colour by index 0..7 (full-scale or zero per channel): white, yellow, cyan, green, magenta, red, blue, black.
- Modes; the bar index is the top 3 bits of an x value truncated to log2(H_ACTIVE) bits:
  - 0 EXT: ext_rgb passthrough.
  - 1 BARS: bar colour from x.
  - 2 PALETTE: rgb = x[log2(H_ACTIVE)-1 -: RGB_W]. If log2(H_ACTIVE)<RGB_W, left-justify and zero-fill.
  - 3 CHECKER: all ones if x[4]^y[4], else 0.
  - 4 RAMP: each channel = top bits of x, giving a grey ramp.
  - 5 SCROLL_BARS: bars on (x+scroll) mod H_ACTIVE.
  - 6 COMPOSITE: y<BAND_H → EXT; y<4*BAND_H → PALETTE; else → BARS.
  - 7 SOLID: all ones.
- x ≥ H_ACTIVE with active_video=1 has truncated-index behaviour; it is not an error.
- mode changes are never visible mid-frame; only frame_start commits.

Decomposition:
- Package ntsc_pattern_pkg holds:
  - mode localparams MODE_EXT..MODE_SOLID (3-bit)
  - the bar colour table as 3-bit {R,G,B} flags
  - the function next_mode()
- One sub-module, ntsc_pattern_core: combinational (x, y, scroll, ext_rgb, mode) → colour.
- The top holds pending/mode/dwell/scroll registers and the output register.

Test Plan:
- Reset: hold rst=0 for 3 clks with random inputs → rgb=0, mode=6, scroll=0. Release; first frame_start → mode stays 6.
- Manual: mode_load with mode_in=1 mid-frame → mode stays 6 until frame_start, then 1. At x=64 → rgb=8'hFC (yellow, 3-3-2), 1 clk after x. At x=448 → 0.
- Simultaneous: mode_load(mode_in=7) in the same cycle as frame_start → mode=7 next cycle; an active pixel → 8'hFF.
- Auto-cycle: DWELL_FRAMES=2, auto_en=1, start at mode 7 → after 2 frame_starts mode=1, after 4 mode=2. mode_load(5) mid-dwell → dwell cleared; commits 5 at next frame_start.
- Scroll wrap: SCROLL_STEP=2, apply 256 frame_starts → scroll=0. Mode 5 with scroll=64, x=0 → yellow.
- Composite/blank: mode 6, ext_rgb=8'hA5, y=10 → 8'hA5. y=100, x=256 → 8'h80. active_video=0 → 0.
